// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared index helpers for the round-robin arbiter
// Purpose: modulo-N index arithmetic used by the priority picker and the
//          pointer update, so the wrap is explicit for non-power-of-two N.
// Ports:   none (package).
package rr_arbiter_pkg;

    localparam int RR_N_DEFAULT = 4;

    // (a + b) mod n, for a < n and b < n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

    // (idx + 1) mod n, for idx < n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
// Purpose: groups the level-sensitive request vector and the one-hot grant.
// Signals: req[N-1:0] request vector (requester side drives)
//          gnt[N-1:0] registered one-hot-or-zero grant (arbiter drives)
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] gnt;

    modport master (output req, input gnt);
    modport slave  (input req, output gnt);
endinterface

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - combinational rotating priority encoder
// Purpose: finds the first set bit of i_req searching from index i_ptr
//          upward and wrapping modulo N.
// Ports:   i_req[N-1:0]       request vector
//          i_ptr[PTR_W-1:0]   index of the highest-priority requester (< N)
//          o_winner[PTR_W-1:0] index of the selected requester
//          o_valid            at least one request is set
module rr_prio_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N     = RR_N_DEFAULT,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_winner,
    output logic             o_valid
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    int             w_off;

    assign w_dbl = {i_req, i_req};

    always_comb begin
        // Rotating the doubled vector right by ptr puts requester ptr at
        // bit 0; a plain lowest-bit search then yields the offset from ptr.
        w_rot    = N'(w_dbl >> i_ptr);
        o_valid  = 1'b0;
        w_off    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_off   = k;
            end
        end
        o_winner = PTR_W'(wrap_add(int'(i_ptr), w_off, N));
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-requester round-robin arbiter with registered grant
// Purpose: grants at most one active requester per clock, searching from a
//          rotating pointer that moves just past each winner.
// Ports:   clk  sole clock, rising edge
//          rst  synchronous active-high reset
//          bus  rr_arbiter_if.slave: req in, gnt out (one cycle after req)
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int N     = RR_N_DEFAULT,
    localparam int PTR_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    rr_arbiter_if.slave     bus
);

    logic [N-1:0]     r_gnt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_winner;
    logic             w_valid;

    rr_prio_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else if (w_valid) begin
            r_gnt <= N'(1) << w_winner;
            // The winner drops to lowest priority next cycle.
            r_ptr <= PTR_W'(wrap_inc(int'(w_winner), N));
        end else begin
            // Idle cycle: pointer keeps its place in the rotation.
            r_gnt <= '0;
        end
    end

    assign bus.gnt = r_gnt;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter (N=4)
module tb_rr_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arbiter_if #(.N(N)) bus ();

    rr_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] exp_q[$];
    int           m_ptr = 0;
    int           cnt[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: walk from m_ptr upward modulo N; first active bit wins.
    task automatic model(input logic [N-1:0] rq, input logic rs, output logic [N-1:0] eg);
        bit found;
        eg    = '0;
        found = 0;
        if (rs) begin
            m_ptr = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && rq[idx]) begin
                    found   = 1;
                    eg[idx] = 1'b1;
                    m_ptr   = (idx + 1) % N;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, push expectation, then compare after the edge.
    task automatic cycle(input logic [N-1:0] rq, input logic rs, input string tag);
        logic [N-1:0] eg;
        logic [N-1:0] g;
        bus.req = rq;
        rst     = rs;
        model(rq, rs, eg);
        exp_q.push_back(eg);
        @(posedge clk);
        #1;
        g = bus.gnt;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            chk(tag, 32'(g), 32'(exp_q.pop_front()));
        end
        chk({tag, "_onehot0"}, 32'($onehot0(g)), 32'd1);
        chk({tag, "_inactive"}, 32'(g & ~rq), 32'd0);
    endtask

    initial begin
        bus.req = '0;

        cycle(4'b0000, 1'b1, "reset0");
        cycle(4'b0000, 1'b1, "reset1");
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, "idle");

        cycle(4'b0001, 1'b0, "single0");
        chk("single0_const", 32'(bus.gnt), 32'h1);
        cycle(4'b0000, 1'b0, "single_idle");
        chk("single_idle_const", 32'(bus.gnt), 32'h0);
        cycle(4'b0010, 1'b0, "single1");
        chk("single1_const", 32'(bus.gnt), 32'h2);

        // ptr = 2 here: 0100, 0001, 0010 repeating.
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0111, 1'b0, "partial");
            case (i % 3)
                0: chk("partial_const", 32'(bus.gnt), 32'h4);
                1: chk("partial_const", 32'(bus.gnt), 32'h1);
                default: chk("partial_const", 32'(bus.gnt), 32'h2);
            endcase
        end

        for (int b = 0; b < N; b++) cnt[b] = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b0, "full");
            for (int b = 0; b < N; b++) cnt[b] += int'(bus.gnt[b]);
        end
        for (int b = 0; b < N; b++) chk("full_count", 32'(cnt[b]), 32'd2);

        for (int i = 0; i < 4; i++) cycle(4'b1010, 1'b0, "alt_1010");
        for (int i = 0; i < 4; i++) cycle(4'b0101, 1'b0, "alt_0101");

        // Park the pointer at 3, then reset in the middle of contention.
        cycle(4'b0100, 1'b0, "to_ptr3");
        cycle(4'b1111, 1'b1, "mid_reset");
        chk("mid_reset_const", 32'(bus.gnt), 32'h0);
        cycle(4'b1111, 1'b0, "post_reset");
        chk("post_reset_const", 32'(bus.gnt), 32'h1);

        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0), "random");
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
